// File: rtl/joltage_select_sum.sv
// Streaming "largest K-digit subsequence" selector with a running sum.
// Each lane j holds the best j-digit value seen so far in the current line.

module jss_lane #(
  parameter int VAL_W = 40,
  parameter int KW    = 4,
  parameter int IDX   = 0
)(
  input  logic [VAL_W-1:0] prev,
  input  logic [VAL_W-1:0] cur,
  input  logic [3:0]       d,
  input  logic [KW-1:0]    cnt,
  output logic [VAL_W-1:0] nxt
);
  logic [VAL_W-1:0] cand;

  // prev is only meaningful once IDX digits have already been consumed
  always_comb begin
    cand = (prev << 3) + (prev << 1) + VAL_W'(d);
    nxt  = (cnt >= KW'(IDX) && cand > cur) ? cand : cur;
  end
endmodule

module joltage_select_sum #(
  parameter int MAX_K = 12,
  parameter int VAL_W = 40,
  parameter int SUM_W = 64,
  parameter int CNT_W = 32,
  localparam int KW   = $clog2(MAX_K+1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KW-1:0]    k_sel,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sum_clr,
  output logic             line_valid,
  output logic [VAL_W-1:0] line_value,
  output logic             line_short,
  output logic [SUM_W-1:0] sum_out,
  output logic [CNT_W-1:0] lines_done,
  output logic [2:0]       error
);
  localparam int EW = ((SUM_W > VAL_W) ? SUM_W : VAL_W) + 1;

  typedef enum logic {RUN, FINAL} state_t;
  state_t state, state_nxt;

  logic [MAX_K-1:0][VAL_W-1:0] best_q, best_nxt, prev_v;
  logic [KW-1:0]    cnt, k_r;
  logic             live, in_line;
  logic             acc, fin, dig_ok, k_ok, short_l;
  logic [VAL_W-1:0] sel_val;
  logic [EW-1:0]    add_w;
  logic [2:0]       err_set;

  assign prev_v = {best_q[MAX_K-2:0], VAL_W'(0)};

  for (genvar i = 0; i < MAX_K; i++) begin : g_lane
    jss_lane #(.VAL_W(VAL_W), .KW(KW), .IDX(i)) u_lane (
      .prev (prev_v[i]),
      .cur  (best_q[i]),
      .d    (in_digit),
      .cnt  (cnt),
      .nxt  (best_nxt[i])
    );
  end

  // live keeps in_ready low while reset is asserted and for the edge that releases it
  assign in_ready = live && (state == RUN);
  assign acc      = in_valid && in_ready;
  assign fin      = (state == FINAL);
  assign dig_ok   = (in_digit <= 4'd9);
  assign k_ok     = (k_sel != '0) && (k_sel <= KW'(MAX_K));
  assign short_l  = (cnt < k_r);

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < MAX_K; i++)
      if (k_r == KW'(i+1)) sel_val = best_q[i];
  end

  assign line_valid = fin;
  assign line_short = fin && short_l;
  assign line_value = (fin && !short_l) ? sel_val : '0;

  // Widened add so a carry is visible even when VAL_W exceeds SUM_W
  assign add_w   = EW'(sum_out) + EW'(line_value);
  assign err_set = {fin && !short_l && (|add_w[EW-1:SUM_W]),
                    (fin && short_l) || (acc && !in_line && !k_ok),
                    acc && !dig_ok};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (acc && in_last) state_nxt = FINAL;
      FINAL:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live    <= 1'b0;
      in_line <= 1'b0;
      best_q  <= '0;
      cnt     <= '0;
      k_r     <= '0;
    end else begin
      live <= 1'b1;
      if (acc) begin
        if (!in_line) k_r <= k_ok ? k_sel : KW'(MAX_K);
        in_line <= !in_last;
        if (dig_ok) begin
          best_q <= best_nxt;
          if (cnt != KW'(MAX_K)) cnt <= cnt + 1'b1;
        end
      end
      if (fin) begin
        best_q <= '0;
        cnt    <= '0;
      end
    end
  end

  // Clear has priority over everything the FINAL cycle would record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out    <= '0;
      lines_done <= '0;
      error      <= '0;
    end else if (sum_clr) begin
      sum_out    <= '0;
      lines_done <= '0;
      error      <= '0;
    end else begin
      error <= error | err_set;
      if (fin) lines_done <= lines_done + 1'b1;
      if (fin && !short_l) sum_out <= add_w[SUM_W-1:0];
    end
  end
endmodule

// File: tb/tb_joltage_select_sum.sv
// Bench for joltage_select_sum: directed lines plus random lines checked against
// a greedy digit-selection model; a SUM_W=8 copy exercises sum wrap.
`timescale 1ns/1ps

module tb_joltage_select_sum;
  typedef logic [3:0] dq_t[$];
  typedef struct { longint unsigned val; bit short_l; } exp_t;

  logic        clk = 0, rst_n = 0;
  logic [3:0]  k_sel = 0, in_digit = 0;
  logic        in_last = 0, in_valid = 0, sum_clr = 0;
  logic        a_in_ready, a_line_valid, a_line_short;
  logic [39:0] a_line_value;
  logic [63:0] a_sum_out;
  logic [31:0] a_lines_done;
  logic [2:0]  a_error;
  logic        b_in_ready, b_line_valid, b_line_short;
  logic [39:0] b_line_value;
  logic [7:0]  b_sum_out;
  logic [31:0] b_lines_done;
  logic [2:0]  b_error;

  int n_chk = 0, n_fail = 0;
  exp_t exp_q[$];
  logic [63:0] m_sum;
  logic [7:0]  m_sum8;
  logic [31:0] m_lines;
  logic [2:0]  m_err, m_err8;
  bit          tb_in_line, pend;

  always #5 clk = ~clk;

  joltage_select_sum u_dut (
    .clk(clk), .rst_n(rst_n), .k_sel(k_sel), .in_digit(in_digit), .in_last(in_last),
    .in_valid(in_valid), .in_ready(a_in_ready), .sum_clr(sum_clr),
    .line_valid(a_line_valid), .line_value(a_line_value), .line_short(a_line_short),
    .sum_out(a_sum_out), .lines_done(a_lines_done), .error(a_error));

  joltage_select_sum #(.SUM_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .k_sel(k_sel), .in_digit(in_digit), .in_last(in_last),
    .in_valid(in_valid), .in_ready(b_in_ready), .sum_clr(sum_clr),
    .line_valid(b_line_valid), .line_value(b_line_value), .line_short(b_line_short),
    .sum_out(b_sum_out), .lines_done(b_lines_done), .error(b_error));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Greedy pick: for each output position take the largest digit that still
  // leaves enough digits behind it.
  function automatic exp_t ref_line(input dq_t dq, input int k);
    exp_t r;
    int v[$];
    int kk, pos, bi, bv;
    foreach (dq[i]) if (dq[i] <= 9) v.push_back(int'(dq[i]));
    kk = (k < 1 || k > 12) ? 12 : k;
    r.val = 0;
    r.short_l = (v.size() < kk);
    if (r.short_l) return r;
    pos = 0;
    for (int rr = kk; rr >= 1; rr--) begin
      bv = -1; bi = pos;
      for (int i = pos; i <= v.size() - rr; i++)
        if (v[i] > bv) begin bv = v[i]; bi = i; end
      r.val = r.val * 10 + longint'(bv);
      pos = bi + 1;
    end
    return r;
  endfunction

  function automatic dq_t s2q(input string s);
    dq_t q;
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "A") q.push_back(4'hA);
      else          q.push_back(4'(c - "0"));
    end
    return q;
  endfunction

  task automatic send_line(input dq_t dq, input int k, input int gap_pct, input bit kflip);
    int waited;
    for (int i = 0; i < dq.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      in_valid = 1;
      in_digit = dq[i];
      in_last  = (i == dq.size() - 1);
      k_sel    = (i == 0 || !kflip) ? 4'(k) : 4'($urandom_range(15));
      waited = 0;
      @(negedge clk);
      while (!a_in_ready && waited < 50) begin waited++; @(negedge clk); end
      if (waited >= 50) chk("ready_timeout", 0, 1);
      if (i == dq.size() - 1) exp_q.push_back(ref_line(dq, k));
      @(posedge clk); #1;
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr;
    sum_clr = 1;
    @(posedge clk); #1;
    sum_clr = 0;
  endtask

  // Scoreboard: line results vs model, plus sum/count/error one cycle later
  always @(negedge clk) begin
    exp_t e;
    logic [64:0] t;
    if (!rst_n) begin
      m_sum = 0; m_sum8 = 0; m_lines = 0; m_err = 0; m_err8 = 0;
      tb_in_line = 0; pend = 0;
    end else begin
      if (pend) begin
        chk("sum64", a_sum_out, m_sum);
        chk("lines_done", a_lines_done, m_lines);
        chk("error64", a_error, m_err);
        chk("sum8", b_sum_out, m_sum8);
        chk("error8", b_error, m_err8);
        pend = 0;
      end
      if (a_line_valid || b_line_valid) begin
        chk("line_valid64", a_line_valid, 1);
        chk("line_valid8", b_line_valid, 1);
        chk("ready_in_final", a_in_ready, 0);
        if (exp_q.size() == 0) chk("unexpected_line", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("line_value", a_line_value, e.val);
          chk("line_value8", b_line_value, e.val);
          chk("line_short", a_line_short, e.short_l);
          if (!sum_clr) begin
            m_lines++;
            if (e.short_l) begin m_err[1] = 1; m_err8[1] = 1; end
            else begin
              t = m_sum + e.val;  m_sum = t[63:0];  if (t[64]) m_err[2] = 1;
              t = m_sum8 + e.val; m_sum8 = t[7:0];  if (t[64:8] != 0) m_err8[2] = 1;
            end
          end
        end
        pend = 1;
      end
      if (in_valid && a_in_ready) begin
        if (!sum_clr) begin
          if (!tb_in_line && (k_sel == 0 || k_sel > 12)) begin m_err[1] = 1; m_err8[1] = 1; end
          if (in_digit > 9) begin m_err[0] = 1; m_err8[0] = 1; end
        end
        tb_in_line = !in_last;
      end
      if (sum_clr) begin
        m_sum = 0; m_sum8 = 0; m_lines = 0; m_err = 0; m_err8 = 0;
        pend = 1;
      end
    end
  end

  string L[4] = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};

  initial begin
    dq_t dq;
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", a_in_ready, 0);
    chk("rst_line_valid", a_line_valid, 0);
    chk("rst_sum", a_sum_out, 0);
    chk("rst_lines", a_lines_done, 0);
    chk("rst_error", a_error, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);
    chk("ready_after_rst", a_in_ready, 1);

    foreach (L[i]) send_line(s2q(L[i]), 2, 0, 0);
    idle(4);
    chk("sum_k2", a_sum_out, 357);
    chk("lines_k2", a_lines_done, 4);
    chk("err_k2", a_error, 0);

    pulse_clr();
    foreach (L[i]) send_line(s2q(L[i]), 12, 0, 0);
    idle(4);
    chk("sum_k12", a_sum_out, 64'd3121910778619);

    pulse_clr();
    foreach (L[i]) send_line(s2q(L[i]), (i % 2) ? 12 : 2, 0, 1);
    idle(4);
    chk("sum_kmix", a_sum_out, 64'd1700022223406);

    pulse_clr();
    send_line(s2q("5"), 2, 0, 0);
    idle(4);
    chk("short_err", a_error, 3'b010);
    chk("short_sum", a_sum_out, 0);
    pulse_clr();
    send_line(s2q("98A7"), 2, 0, 0);
    idle(4);
    chk("bad_digit_err", a_error, 3'b001);
    chk("bad_digit_sum", a_sum_out, 98);
    send_line(s2q("A"), 3, 0, 0);
    idle(4);
    chk("empty_line_err", a_error, 3'b011);
    pulse_clr();
    send_line(s2q("9876543210987"), 14, 0, 0);
    idle(4);
    chk("bad_k_err", a_error, 3'b010);
    chk("bad_k_sum", a_sum_out, 64'd987654321987);

    pulse_clr();
    send_line(s2q("200"), 3, 0, 0);
    send_line(s2q("100"), 3, 0, 0);
    idle(4);
    chk("wrap_sum8", b_sum_out, 44);
    chk("wrap_err8", b_error, 3'b100);
    chk("wide_sum", a_sum_out, 300);

    send_line(s2q("55"), 2, 0, 0);
    sum_clr = 1;
    @(posedge clk); #1;
    sum_clr = 0;
    idle(3);
    chk("clr_final_sum", a_sum_out, 0);
    chk("clr_final_lines", a_lines_done, 0);

    in_valid = 1; in_last = 0; k_sel = 2;
    foreach (L[0][i]) if (i < 3) begin in_digit = 4'(L[0][i] - "0"); @(posedge clk); #1; end
    rst_n = 0;
    in_valid = 0;
    @(negedge clk);
    chk("midrst_ready", a_in_ready, 0);
    chk("midrst_valid", a_line_valid, 0);
    chk("midrst_sum", a_sum_out, 0);
    chk("midrst_error", a_error, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);
    send_line(s2q("818181911112111"), 2, 0, 0);
    idle(4);
    chk("post_rst_sum", a_sum_out, 92);

    for (int n = 0; n < 1000; n++) begin
      dq.delete();
      len = $urandom_range(1, 100);
      for (int i = 0; i < len; i++)
        dq.push_back(($urandom_range(99) < 2) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(9)));
      send_line(dq, $urandom_range(1, 12), 20, $urandom_range(1));
    end
    idle(5);
    chk("drain", exp_q.size(), 0);
    chk("final_sum", a_sum_out, m_sum);
    chk("final_lines", a_lines_done, m_lines);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
